// File: rtl/computer_if.sv
// CPU-to-RAM bus: registered-read, synchronous-write single-port memory access.
interface computer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  we;

   modport master (output addr, output wdata, output we, input rdata);
   modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/computer.sv
// SAP-2-style 8-bit computer: multi-cycle microsequenced CPU plus a 16x8 unified RAM.
// Every instruction spends 5 fetch/decode cycles followed by 2 or 4 execute cycles.
package arch_defs_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 4;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_STA = 4'h4,
      OP_LDI = 4'h5,
      OP_JMP = 4'h6,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_t;
endpackage

module cpu_register #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] latched_data
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         latched_data <= '0;
      end else if (load) begin
         latched_data <= data;
      end
   end
endmodule

module ram import arch_defs_pkg::*; (
   input  logic      clk,
   input  logic      freeze,
   computer_if.slave bus
);
   logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

   // Read is always registered from the current address, so a read in the
   // cycle after a write naturally returns the freshly written word.
   always_ff @(posedge clk) begin
      if (bus.we && !freeze) begin
         mem[bus.addr] <= bus.wdata;
      end
      bus.rdata <= mem[bus.addr];
   end

   task dump();
      for (int i = 0; i < 2**ADDR_WIDTH; i++) begin
         $display("[RAM] %0h: %02h", i, mem[i]);
      end
   endtask
endmodule

module cpu import arch_defs_pkg::*; (
   input  logic                  clk,
   input  logic                  reset,
   computer_if.master            bus,
   output logic [DATA_WIDTH-1:0] final_out,
   output logic                  halt
);
   typedef enum logic [1:0] {S_INIT, S_FETCH, S_EXEC, S_HALT} state_t;

   state_t                state;
   state_t                state_next;
   logic [2:0]            step;
   logic [2:0]            step_next;
   logic [2:0]            last_step;

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] mar;
   logic [DATA_WIDTH-1:0] ir;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [DATA_WIDTH-1:0] a_in;
   logic [DATA_WIDTH-1:0] alu;
   logic [3:0]            opcode;
   logic [ADDR_WIDTH-1:0] operand;

   logic mar_from_pc, mar_from_ir, ir_load, pc_inc, pc_load;
   logic a_load_mem, a_load_imm, a_load_alu, sub, b_load;
   logic out_load, ram_we, halt_set, a_load;

   assign opcode    = ir[7:4];
   assign operand   = ir[ADDR_WIDTH-1:0];
   assign last_step = (opcode == OP_LDA || opcode == OP_ADD ||
                       opcode == OP_SUB || opcode == OP_STA) ? 3'd3 : 3'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_INIT;
         step  <= 3'd0;
      end else begin
         state <= state_next;
         step  <= step_next;
      end
   end

   always_comb begin
      state_next = state;
      step_next  = step;
      case (state)
         S_INIT: begin
            state_next = S_FETCH;
            step_next  = 3'd0;
         end
         S_FETCH: begin
            if (step == 3'd4) begin
               state_next = S_EXEC;
               step_next  = 3'd0;
            end else begin
               step_next = step + 3'd1;
            end
         end
         S_EXEC: begin
            if (step == last_step) begin
               state_next = (opcode == OP_HLT) ? S_HALT : S_FETCH;
               step_next  = 3'd0;
            end else begin
               step_next = step + 3'd1;
            end
         end
         S_HALT: begin
            state_next = S_HALT;
         end
         default: begin
            state_next = S_INIT;
            step_next  = 3'd0;
         end
      endcase
   end

   // Micro-operations per (state, step); unlisted opcodes fall through as NOP.
   always_comb begin
      mar_from_pc = 1'b0;
      mar_from_ir = 1'b0;
      ir_load     = 1'b0;
      pc_inc      = 1'b0;
      pc_load     = 1'b0;
      a_load_mem  = 1'b0;
      a_load_imm  = 1'b0;
      a_load_alu  = 1'b0;
      sub         = 1'b0;
      b_load      = 1'b0;
      out_load    = 1'b0;
      ram_we      = 1'b0;
      halt_set    = 1'b0;
      if (state == S_FETCH) begin
         mar_from_pc = (step == 3'd0);
         ir_load     = (step == 3'd2);
         pc_inc      = (step == 3'd3);
      end else if (state == S_EXEC) begin
         case (opcode)
            OP_LDA: begin
               mar_from_ir = (step == 3'd0);
               a_load_mem  = (step == 3'd3);
            end
            OP_ADD, OP_SUB: begin
               mar_from_ir = (step == 3'd0);
               b_load      = (step == 3'd2);
               a_load_alu  = (step == 3'd3);
               sub         = (opcode == OP_SUB);
            end
            OP_STA: begin
               mar_from_ir = (step == 3'd0);
               ram_we      = (step == 3'd2);
            end
            OP_LDI: a_load_imm = (step == 3'd1);
            OP_JMP: pc_load    = (step == 3'd0);
            OP_OUT: out_load   = (step == 3'd0);
            OP_HLT: halt_set   = (step == 3'd1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc   <= '0;
         mar  <= '0;
         halt <= 1'b0;
      end else begin
         if (mar_from_pc) begin
            mar <= pc;
         end else if (mar_from_ir) begin
            mar <= operand;
         end
         if (pc_load) begin
            pc <= operand;
         end else if (pc_inc) begin
            pc <= pc + 4'd1;
         end
         if (halt_set) begin
            halt <= 1'b1;
         end
      end
   end

   assign alu    = sub ? (a_q - b_q) : (a_q + b_q);
   assign a_load = a_load_mem | a_load_imm | a_load_alu;

   always_comb begin
      a_in = bus.rdata;
      if (a_load_imm) begin
         a_in = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, operand};
      end else if (a_load_alu) begin
         a_in = alu;
      end
   end

   cpu_register #(.WIDTH(DATA_WIDTH)) u_register_A (
      .clk(clk), .reset(reset), .load(a_load), .data(a_in), .latched_data(a_q)
   );
   cpu_register #(.WIDTH(DATA_WIDTH)) u_register_B (
      .clk(clk), .reset(reset), .load(b_load), .data(bus.rdata), .latched_data(b_q)
   );
   cpu_register #(.WIDTH(DATA_WIDTH)) u_register_IR (
      .clk(clk), .reset(reset), .load(ir_load), .data(bus.rdata), .latched_data(ir)
   );
   cpu_register #(.WIDTH(DATA_WIDTH)) u_register_OUT (
      .clk(clk), .reset(reset), .load(out_load), .data(a_q), .latched_data(final_out)
   );

   assign bus.addr  = mar;
   assign bus.wdata = a_q;
   assign bus.we    = ram_we;
endmodule

module computer import arch_defs_pkg::*; (
   input  logic                  clk,
   input  logic                  reset,
   output logic [DATA_WIDTH-1:0] final_out
);
   logic halt;

   computer_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

   cpu u_cpu (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .final_out (final_out),
      .halt      (halt)
   );

   ram u_ram (
      .clk    (clk),
      .freeze (halt),
      .bus    (bus)
   );
endmodule

// File: tb/tb_computer.sv
// Bench for the SAP-2 computer: directed vector table, hand-written corner sequences,
// and random programs checked against an instruction-level model of the ISA.
module tb_computer;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] final_out;

   int tests = 0;
   int fails = 0;

   computer dut (
      .clk       (clk),
      .reset     (reset),
      .final_out (final_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] prog;
      int           clocks;
      logic [7:0]   exp_a;
      logic [7:0]   exp_out;
      logic         exp_halt;
      logic [3:0]   exp_pc;
   } vec_t;

   // Byte n of a program image sits at bits [n*8 +: 8].
   localparam logic [127:0] P_LDST = 128'h00000000_00000000_000000F0_1F504F53;
   localparam logic [127:0] P_ALU  = 128'h03FE0000_00000000_0000F0E0_3FE02F1E;
   localparam logic [127:0] P_JMP  = 128'h00000000_00000000_000000F0_E0596355;
   localparam logic [127:0] P_NOPS = 128'h0;

   logic [7:0] m_mem [16];
   logic [7:0] m_a;
   logic [7:0] m_out;
   logic [3:0] m_pc;
   logic       m_halt;
   int         m_cycles;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [127:0] prog);
      @(negedge clk);
      reset = 1'b0;
      #1;
      for (int i = 0; i < 16; i++) begin
         dut.u_ram.mem[i] = prog[i*8 +: 8];
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic runClocks(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic checkRegs(input string tag, input logic [7:0] a, input logic [7:0] o,
                            input logic h, input logic [3:0] p);
      checkOutput({tag, " A"}, dut.u_cpu.u_register_A.latched_data, a);
      checkOutput({tag, " final_out"}, final_out, o);
      checkOutput({tag, " halt"}, dut.halt, h);
      checkOutput({tag, " PC"}, dut.u_cpu.pc, p);
   endtask

   // Instruction-level reference: one loop iteration per instruction, cycle cost by opcode.
   task automatic modelRun(input int max_instr);
      logic [7:0] ir;
      logic [3:0] op;
      logic [3:0] arg;
      m_a = 8'h00; m_out = 8'h00; m_pc = 4'h0; m_halt = 1'b0; m_cycles = 1;
      for (int n = 0; n < max_instr && !m_halt; n++) begin
         ir  = m_mem[m_pc];
         op  = ir[7:4];
         arg = ir[3:0];
         m_pc = m_pc + 4'd1;
         case (op)
            4'h1: m_a = m_mem[arg];
            4'h2: m_a = m_a + m_mem[arg];
            4'h3: m_a = m_a - m_mem[arg];
            4'h4: m_mem[arg] = m_a;
            4'h5: m_a = {4'h0, arg};
            4'h6: m_pc = arg;
            4'hE: m_out = m_a;
            4'hF: m_halt = 1'b1;
            default: ;
         endcase
         m_cycles += (op >= 4'h1 && op <= 4'h4) ? 9 : 7;
      end
   endtask

   initial begin
      vec_t         vecs [14];
      logic [3:0]   ops [11];
      logic [127:0] prog;
      logic [7:0]   word;

      vecs[0]  = '{P_LDST,   0, 8'h00, 8'h00, 1'b0, 4'h0};
      vecs[1]  = '{P_LDST,   1, 8'h00, 8'h00, 1'b0, 4'h0};
      vecs[2]  = '{P_LDST,   7, 8'h00, 8'h00, 1'b0, 4'h1};
      vecs[3]  = '{P_LDST,   8, 8'h03, 8'h00, 1'b0, 4'h1};
      vecs[4]  = '{P_LDST,  17, 8'h03, 8'h00, 1'b0, 4'h2};
      vecs[5]  = '{P_LDST,  24, 8'h00, 8'h00, 1'b0, 4'h3};
      vecs[6]  = '{P_LDST,  33, 8'h03, 8'h00, 1'b0, 4'h4};
      vecs[7]  = '{P_LDST,  39, 8'h03, 8'h00, 1'b0, 4'h5};
      vecs[8]  = '{P_LDST,  40, 8'h03, 8'h00, 1'b1, 4'h5};
      vecs[9]  = '{P_ALU,   26, 8'h01, 8'h01, 1'b0, 4'h3};
      vecs[10] = '{P_ALU,   49, 8'hFE, 8'hFE, 1'b1, 4'h6};
      vecs[11] = '{P_JMP,   29, 8'h05, 8'h05, 1'b1, 4'h5};
      vecs[12] = '{P_NOPS, 106, 8'h00, 8'h00, 1'b0, 4'hF};
      vecs[13] = '{P_NOPS, 113, 8'h00, 8'h00, 1'b0, 4'h0};

      ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hE, 4'hF};

      for (int v = 0; v < 14; v++) begin
         applyStimulus(vecs[v].prog);
         runClocks(vecs[v].clocks);
         checkRegs($sformatf("vec%0d@%0d", v, vecs[v].clocks), vecs[v].exp_a,
                   vecs[v].exp_out, vecs[v].exp_halt, vecs[v].exp_pc);
      end

      // STA write lands at the end of its third execute cycle.
      applyStimulus(P_LDST);
      runClocks(15);
      checkOutput("sta before write", dut.u_ram.mem[15], 8'h00);
      runClocks(2);
      checkOutput("sta after write", dut.u_ram.mem[15], 8'h03);

      // Reset in the middle of STA aborts it with no clock edge needed.
      applyStimulus(P_LDST);
      runClocks(14);
      checkOutput("pre-abort A", dut.u_cpu.u_register_A.latched_data, 8'h03);
      reset = 1'b0;
      #1;
      checkRegs("async reset", 8'h00, 8'h00, 1'b0, 4'h0);
      runClocks(3);
      checkOutput("aborted sta ram", dut.u_ram.mem[15], 8'h00);
      @(negedge clk);
      reset = 1'b1;
      runClocks(8);
      checkRegs("restart", 8'h03, 8'h00, 1'b0, 4'h1);

      applyStimulus(P_JMP);
      runClocks(22);
      checkOutput("out before reset", final_out, 8'h05);
      reset = 1'b0;
      #1;
      checkOutput("out async clear", final_out, 8'h00);

      // Halted machine stays frozen.
      applyStimulus(P_ALU);
      runClocks(69);
      checkRegs("frozen", 8'hFE, 8'hFE, 1'b1, 4'h6);
      checkOutput("frozen ram0", dut.u_ram.mem[0], 8'h1E);
      checkOutput("frozen ram14", dut.u_ram.mem[14], 8'hFE);
      checkOutput("frozen ram15", dut.u_ram.mem[15], 8'h03);
      dut.u_ram.dump();

      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < 16; i++) begin
            word = {ops[$urandom_range(0, 10)], 4'($urandom_range(0, 15))};
            if ($urandom_range(0, 3) == 0) word = 8'($urandom);
            m_mem[i] = word;
            prog[i*8 +: 8] = word;
         end
         modelRun(12);
         applyStimulus(prog);
         runClocks(m_cycles);
         checkRegs($sformatf("rand%0d", r), m_a, m_out, m_halt, m_pc);
         for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("rand%0d ram%0d", r, i), dut.u_ram.mem[i], m_mem[i]);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
